// File: rtl/edge_event_recorder.sv
// Samples four control signals every clock and queues each change of the sampled
// value as a timestamped event, drained through a valid/ready port.
module edge_event_recorder #(
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned TS_WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    varA,
    input  logic                    varB,
    input  logic                    varC,
    input  logic                    varD,
    output logic                    evt_valid,
    input  logic                    evt_ready,
    output logic [TS_WIDTH-1:0]     evt_ts,
    output logic [3:0]              evt_value,
    output logic [3:0]              evt_diff,
    output logic [$clog2(DEPTH):0]  evt_count,
    output logic                    overflow,
    output logic [7:0]              drop_count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [TS_WIDTH-1:0] ts;
        logic [3:0]          value;
        logic [3:0]          diff;
    } entry_t;

    logic [3:0]          sampleNow;
    logic [3:0]          sampleQ;
    logic [3:0]          prevQ;
    logic                armed;
    logic [TS_WIDTH-1:0] tsQ;
    logic [TS_WIDTH-1:0] sampleTsQ;

    entry_t              mem [DEPTH];
    entry_t              newEntry;
    entry_t              head;
    logic [CNT_W-1:0]    wrPtr;
    logic [CNT_W-1:0]    rdPtr;
    logic [CNT_W-1:0]    countQ;
    logic [CNT_W-1:0]    countNext;
    logic                evtValidQ;
    logic                overflowQ;
    logic [7:0]          dropCountQ;

    logic                evtHit;
    logic                isFull;
    logic                doPop;
    logic                doPush;
    logic                doDrop;

    assign sampleNow = {varD, varC, varB, varA};

    // Sampling front end; while unarmed the first sample seeds prevQ so it cannot raise an event.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sampleQ   <= '0;
            prevQ     <= '0;
            armed     <= 1'b0;
            tsQ       <= '0;
            sampleTsQ <= '0;
        end else begin
            sampleQ   <= sampleNow;
            prevQ     <= armed ? sampleQ : sampleNow;
            armed     <= 1'b1;
            tsQ       <= tsQ + TS_WIDTH'(1);
            sampleTsQ <= tsQ;
        end
    end

    // Event detection and FIFO push/pop/drop decisions.
    always_comb begin
        evtHit         = armed && (sampleQ != prevQ);
        isFull         = (countQ == CNT_W'(DEPTH));
        doPop          = evtValidQ && evt_ready;
        doPush         = evtHit && (!isFull || doPop);
        doDrop         = evtHit && isFull && !doPop;
        newEntry.ts    = sampleTsQ;
        newEntry.value = sampleQ;
        newEntry.diff  = sampleQ ^ prevQ;
    end

    always_comb begin
        countNext = countQ;
        if (doPush && !doPop) begin
            countNext = countQ + CNT_W'(1);
        end else if (!doPush && doPop) begin
            countNext = countQ - CNT_W'(1);
        end
    end

    // Event storage; cleared on reset so the head outputs read zero when empty after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (doPush) begin
            mem[wrPtr[PTR_W-1:0]] <= newEntry;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPtr      <= '0;
            rdPtr      <= '0;
            countQ     <= '0;
            evtValidQ  <= 1'b0;
            overflowQ  <= 1'b0;
            dropCountQ <= '0;
        end else begin
            if (doPush) begin
                wrPtr <= wrPtr + CNT_W'(1);
            end
            if (doPop) begin
                rdPtr <= rdPtr + CNT_W'(1);
            end
            countQ    <= countNext;
            evtValidQ <= (countNext != '0);
            if (doDrop) begin
                overflowQ <= 1'b1;
                if (dropCountQ != 8'hFF) begin
                    dropCountQ <= dropCountQ + 8'd1;
                end
            end
        end
    end

    assign head       = mem[rdPtr[PTR_W-1:0]];
    assign evt_valid  = evtValidQ;
    assign evt_ts     = head.ts;
    assign evt_value  = head.value;
    assign evt_diff   = head.diff;
    assign evt_count  = countQ;
    assign overflow   = overflowQ;
    assign drop_count = dropCountQ;

endmodule

// File: tb/tb_edge_event_recorder.sv
// Directed bench for edge_event_recorder: per-cycle vector table plus hand-written
// overflow, full-with-pop, saturation, timestamp-wrap and async-reset sequences.
module tb_edge_event_recorder;

    localparam int unsigned DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  vin = 4'b0000;
    logic        ready = 1'b0;

    logic        aValid, bValid;
    logic [15:0] aTs;
    logic [3:0]  bTs;
    logic [3:0]  aValue, aDiff, bValue, bDiff;
    logic [3:0]  aCount, bCount;
    logic        aOvf, bOvf;
    logic [7:0]  aDrop, bDrop;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    edge_event_recorder #(.DEPTH(DEPTH), .TS_WIDTH(16)) dut (
        .clk(clk), .rst(rst),
        .varA(vin[0]), .varB(vin[1]), .varC(vin[2]), .varD(vin[3]),
        .evt_valid(aValid), .evt_ready(ready), .evt_ts(aTs),
        .evt_value(aValue), .evt_diff(aDiff), .evt_count(aCount),
        .overflow(aOvf), .drop_count(aDrop)
    );

    edge_event_recorder #(.DEPTH(DEPTH), .TS_WIDTH(4)) dutNarrow (
        .clk(clk), .rst(rst),
        .varA(vin[0]), .varB(vin[1]), .varC(vin[2]), .varD(vin[3]),
        .evt_valid(bValid), .evt_ready(ready), .evt_ts(bTs),
        .evt_value(bValue), .evt_diff(bDiff), .evt_count(bCount),
        .overflow(bOvf), .drop_count(bDrop)
    );

    typedef struct {
        bit         doRst;
        logic [3:0] vars;
        logic       rdy;
        logic       expValid;
        int         expCount;
        logic       expOvf;
        int         expTs;
        logic [3:0] expVal;
        logic [3:0] expDiff;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(bit r, logic [3:0] v, logic rd, logic ev, int ec,
                                logic eo, int et, logic [3:0] eval, logic [3:0] ed);
        vec_t x;
        x.doRst = r; x.vars = v; x.rdy = rd; x.expValid = ev; x.expCount = ec;
        x.expOvf = eo; x.expTs = et; x.expVal = eval; x.expDiff = ed;
        return x;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Asserts reset, checks the asynchronous clear, releases at a falling edge.
    task automatic doReset(input logic [3:0] v);
        rst = 1'b1; vin = v; ready = 1'b0;
        #1;
        chk("rst valid", 32'(aValid), 32'd0);
        chk("rst count", 32'(aCount), 32'd0);
        chk("rst ovf",   32'(aOvf),   32'd0);
        chk("rst drop",  32'(aDrop),  32'd0);
        chk("rst ts",    32'(aTs),    32'd0);
        chk("rst value", 32'(aValue), 32'd0);
        chk("rst diff",  32'(aDiff),  32'd0);
        chk("rst nvalid", 32'(bValid), 32'd0);
        chk("rst ncount", 32'(bCount), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        // idle after reset for 10 edges
        vecs.push_back(mk(1, 4'b0000, 0, 0, 0, 0, 0, 4'h0, 4'h0));
        for (int i = 0; i < 9; i++) vecs.push_back(mk(0, 4'b0000, 0, 0, 0, 0, 0, 4'h0, 4'h0));
        // single varB change at edge 1, ready held high
        vecs.push_back(mk(1, 4'b0000, 1, 0, 0, 0, 0, 4'h0, 4'h0));
        vecs.push_back(mk(0, 4'b0010, 1, 0, 0, 0, 0, 4'h0, 4'h0));
        vecs.push_back(mk(0, 4'b0010, 1, 1, 1, 0, 1, 4'b0010, 4'b0010));
        vecs.push_back(mk(0, 4'b0010, 1, 0, 0, 0, 0, 4'h0, 4'h0));
        vecs.push_back(mk(0, 4'b0010, 1, 0, 0, 0, 0, 4'h0, 4'h0));
        // varA toggled on three edges, then drained
        vecs.push_back(mk(1, 4'b0000, 0, 0, 0, 0, 0, 4'h0, 4'h0));
        vecs.push_back(mk(0, 4'b0001, 0, 0, 0, 0, 0, 4'h0, 4'h0));
        vecs.push_back(mk(0, 4'b0000, 0, 1, 1, 0, 1, 4'b0001, 4'b0001));
        vecs.push_back(mk(0, 4'b0001, 0, 1, 2, 0, 1, 4'b0001, 4'b0001));
        vecs.push_back(mk(0, 4'b0001, 0, 1, 3, 0, 1, 4'b0001, 4'b0001));
        vecs.push_back(mk(0, 4'b0001, 1, 1, 2, 0, 2, 4'b0000, 4'b0001));
        vecs.push_back(mk(0, 4'b0001, 1, 1, 1, 0, 3, 4'b0001, 4'b0001));
        vecs.push_back(mk(0, 4'b0001, 1, 0, 0, 0, 0, 4'h0, 4'h0));

        foreach (vecs[i]) begin
            if (vecs[i].doRst) doReset(4'b0000);
            vin   = vecs[i].vars;
            ready = vecs[i].rdy;
            tick();
            chk($sformatf("vec%0d valid", i), 32'(aValid), 32'(vecs[i].expValid));
            chk($sformatf("vec%0d count", i), 32'(aCount), 32'(vecs[i].expCount));
            chk($sformatf("vec%0d ovf", i),   32'(aOvf),   32'(vecs[i].expOvf));
            if (vecs[i].expValid) begin
                chk($sformatf("vec%0d ts", i),    32'(aTs),    32'(vecs[i].expTs));
                chk($sformatf("vec%0d value", i), 32'(aValue), 32'(vecs[i].expVal));
                chk($sformatf("vec%0d diff", i),  32'(aDiff),  32'(vecs[i].expDiff));
            end
        end

        // overflow: 10 changes into an 8-deep FIFO, then drain the first 8 in order
        doReset(4'b0000);
        tick();
        for (int k = 1; k <= 10; k++) begin
            vin = (k % 2 != 0) ? 4'b0001 : 4'b0000;
            tick();
        end
        tick();
        chk("ovf count", 32'(aCount), 32'(DEPTH));
        chk("ovf flag",  32'(aOvf),   32'd1);
        chk("ovf drops", 32'(aDrop),  32'd2);
        ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("ovf drain%0d valid", i), 32'(aValid), 32'd1);
            chk($sformatf("ovf drain%0d ts", i),    32'(aTs),    32'(i + 1));
            chk($sformatf("ovf drain%0d value", i), 32'(aValue), ((i + 1) % 2 != 0) ? 32'd1 : 32'd0);
            chk($sformatf("ovf drain%0d diff", i),  32'(aDiff),  32'd1);
            tick();
        end
        chk("ovf empty valid", 32'(aValid), 32'd0);
        chk("ovf empty count", 32'(aCount), 32'd0);
        chk("ovf sticky",      32'(aOvf),   32'd1);

        // full FIFO with a push and pop on the same edge
        doReset(4'b0000);
        tick();
        for (int k = 1; k <= 9; k++) begin
            vin = (k % 2 != 0) ? 4'b0001 : 4'b0000;
            tick();
        end
        chk("fullpop pre count", 32'(aCount), 32'(DEPTH));
        ready = 1'b1;
        tick();
        chk("fullpop count", 32'(aCount), 32'(DEPTH));
        chk("fullpop ovf",   32'(aOvf),   32'd0);
        chk("fullpop drops", 32'(aDrop),  32'd0);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("fullpop drain%0d ts", i),    32'(aTs),    32'(i + 2));
            chk($sformatf("fullpop drain%0d value", i), 32'(aValue), ((i + 2) % 2 != 0) ? 32'd1 : 32'd0);
            tick();
        end
        chk("fullpop empty", 32'(aValid), 32'd0);

        // drop counter saturation
        doReset(4'b0000);
        tick();
        for (int k = 1; k <= 270; k++) begin
            vin = (k % 2 != 0) ? 4'b0001 : 4'b0000;
            tick();
        end
        tick();
        chk("sat drops", 32'(aDrop),  32'd255);
        chk("sat count", 32'(aCount), 32'(DEPTH));

        // timestamp wrap on the 4-bit instance: change sampled at edge 17
        doReset(4'b0000);
        for (int k = 0; k <= 16; k++) tick();
        vin = 4'b0001;
        tick();
        tick();
        chk("wrap valid",  32'(bValid), 32'd1);
        chk("wrap ts4",    32'(bTs),    32'd1);
        chk("wrap value",  32'(bValue), 32'd1);
        chk("wrap ts16",   32'(aTs),    32'd17);
        vin = 4'b0000;
        tick();
        vin = 4'b0001;
        tick();
        tick();
        chk("pre-rst count",  32'(aCount), 32'd3);
        chk("pre-rst ncount", 32'(bCount), 32'd3);

        // asynchronous reset mid-operation (checked inside doReset), then re-arm with nonzero inputs
        #2;
        doReset(4'b0101);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk($sformatf("rearm%0d valid", k), 32'(aValid), 32'd0);
            chk($sformatf("rearm%0d count", k), 32'(aCount), 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
